// File: rtl/merge_stream_out_pkg.sv
// Shared types and helpers for the merge-network stream reader.
package merge_stream_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int CNT_W = 4;

    function automatic int idx_width(input int n);
        return $clog2(2 * n);
    endfunction

    function automatic int elem_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/merge_stream_out_if.sv
// Start / merged-bus / output-stream bundle between the merge reader and its environment.
interface merge_stream_out_if
    import merge_stream_out_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int n     = 8
);
    logic                      start;
    logic [2*n*WIDTH-1:0]      in_c;
    logic                      busy;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;
    logic [idx_width(n)-1:0]   out_idx;
    logic                      done;
    logic                      order_err;

    modport master (
        output start, in_c, out_ready,
        input  busy, out_data, out_valid, out_last, out_idx, done, order_err
    );

    modport slave (
        input  start, in_c, out_ready,
        output busy, out_data, out_valid, out_last, out_idx, done, order_err
    );
endinterface

// File: rtl/merge_stream_out_stream_elem_mux.sv
// Combinational 2n-to-1 element selector over the snapshot register.
module stream_elem_mux
    import merge_stream_out_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int NE    = 16,
    parameter int SEL_W = $clog2(NE)
) (
    input  logic [NE*WIDTH-1:0] bus_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic [WIDTH-1:0]    elem_o
);
    logic [NE-1:0][WIDTH-1:0] elems;

    for (genvar k = 0; k < NE; k++) begin : g_elem
        assign elems[k] = bus_i[elem_lsb(k, WIDTH) +: WIDTH];
    end

    assign elem_o = elems[sel_i];
endmodule

// File: rtl/merge_stream_out.sv
// Reader for the odd-even merger: settle, snapshot the merged bus, stream it out
// over valid/ready while checking non-decreasing order.
module merge_stream_out
    import merge_stream_out_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int n      = 8,
    parameter int SETTLE = 1
) (
    input logic              clk,
    input logic              rst,
    merge_stream_out_if.slave io
);
    localparam int NE    = 2 * n;
    localparam int IDX_W = idx_width(n);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NE - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NE*WIDTH-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic                err_q, err_d;
    logic [WIDTH-1:0]    cur;
    logic                xfer;

    stream_elem_mux #(.WIDTH(WIDTH), .NE(NE), .SEL_W(IDX_W)) u_mux (
        .bus_i  (snap_q),
        .sel_i  (idx_q),
        .elem_o (cur)
    );

    // Outputs depend only on registered state, never on out_ready.
    assign xfer         = (state_q == ST_STREAM) && io.out_ready;
    assign io.out_valid = (state_q == ST_STREAM);
    assign io.out_data  = cur;
    assign io.out_idx   = idx_q;
    assign io.out_last  = (state_q == ST_STREAM) && (idx_q == IDX_LAST);
    assign io.busy      = (state_q != ST_IDLE);
    assign io.done      = (state_q == ST_DONE);
    assign io.order_err = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        prev_d  = prev_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (io.start) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SET_LAST) begin
                    snap_d  = io.in_c;
                    idx_d   = '0;
                    state_d = ST_STREAM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    if ((idx_q != '0) && (cur < prev_q)) err_d = 1'b1;
                    prev_d = cur;
                    if (idx_q == IDX_LAST) state_d = ST_DONE;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            idx_q   <= '0;
            prev_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_merge_stream_out.sv
// Directed bench for merge_stream_out: cycle table for the basic stream plus
// hand-written backpressure, order, snapshot, reset and settle sequences.
module tb_merge_stream_out;
    localparam int WIDTH = 3;
    localparam int N     = 8;
    localparam int NE    = 2 * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    merge_stream_out_if #(.WIDTH(WIDTH), .n(N)) io ();
    merge_stream_out_if #(.WIDTH(WIDTH), .n(N)) io4 ();

    merge_stream_out #(.WIDTH(WIDTH), .n(N), .SETTLE(1)) dut (
        .clk (clk), .rst (rst), .io (io)
    );
    merge_stream_out #(.WIDTH(WIDTH), .n(N), .SETTLE(4)) dut4 (
        .clk (clk), .rst (rst), .io (io4)
    );

    typedef struct {
        bit start;
        bit rdy;
        bit valid;
        bit busy;
        bit done;
        bit last;
        int idx;
        int data;
    } vec_t;

    vec_t vt[21];
    int   exp_e[NE];
    bit   rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic base_data();
        for (int k = 0; k < NE; k++) exp_e[k] = k / 2;
    endtask

    task automatic viol_data();
        base_data();
        exp_e[5] = 6;
        exp_e[6] = 2;
    endtask

    task automatic set_bus();
        for (int k = 0; k < NE; k++) io.in_c[k*WIDTH +: WIDTH] = WIDTH'(exp_e[k]);
    endtask

    // Start pulse, then consume with the chosen ready pattern, checking every
    // offered element against exp_e and the expected sticky error flag.
    task automatic run_stream(input string tag, input int mode, input bit clobber);
        int k, cyc;
        bit got_done, exp_err;
        k = 0; cyc = 0; got_done = 0; exp_err = 0;
        io.out_ready = 1'b0;
        io.start = 1'b1;
        @(posedge clk); #1;
        io.start = 1'b0;
        while (!got_done && cyc < 200) begin
            io.out_ready = (mode == 0) ? 1'b1 : rdy_pat[cyc % 4];
            if (clobber && io.out_valid) io.in_c = '1;
            #1;
            if (io.out_valid) begin
                if (k >= NE) begin
                    chk({tag, "_extra"}, k, NE - 1);
                    got_done = 1;
                end else begin
                    chk({tag, "_idx"},  int'(io.out_idx), k);
                    chk({tag, "_data"}, int'(io.out_data), exp_e[k]);
                    chk({tag, "_last"}, int'(io.out_last), int'(k == NE - 1));
                    chk({tag, "_err"},  int'(io.order_err), int'(exp_err));
                    if (io.out_ready) begin
                        if (k > 0 && exp_e[k] < exp_e[k-1]) exp_err = 1;
                        k++;
                    end
                end
            end else if (io.done) begin
                chk({tag, "_count"},    k, NE);
                chk({tag, "_err_done"}, int'(io.order_err), int'(exp_err));
                got_done = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!got_done) chk({tag, "_timeout"}, 0, 1);
        #1;
        chk({tag, "_done_once"}, int'(io.done), 0);
        chk({tag, "_idle"},      int'(io.busy), 0);
        chk({tag, "_err_hold"},  int'(io.order_err), int'(exp_err));
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        io.start = 1'b0;  io.out_ready = 1'b0;  io.in_c = '0;
        io4.start = 1'b0; io4.out_ready = 1'b0; io4.in_c = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(io.out_valid), 0);
        chk("rst_busy",  int'(io.busy), 0);
        chk("rst_done",  int'(io.done), 0);
        chk("rst_err",   int'(io.order_err), 0);
        chk("rst_idx",   int'(io.out_idx), 0);
        chk("rst_data",  int'(io.out_data), 0);
        chk("rst_last",  int'(io.out_last), 0);
        chk("rst_busy4", int'(io4.busy), 0);
        rst = 1'b0;

        // Basic stream as an exact cycle table; starts in STREAM and DONE must be ignored.
        vt[0] = '{start:1, rdy:1, valid:0, busy:0, done:0, last:0, idx:0, data:0};
        vt[1] = '{start:0, rdy:1, valid:0, busy:1, done:0, last:0, idx:0, data:0};
        for (int k = 0; k < NE; k++)
            vt[2+k] = '{start:(k == 3), rdy:1, valid:1, busy:1, done:0,
                        last:(k == NE - 1), idx:k, data:k / 2};
        vt[18] = '{start:1, rdy:1, valid:0, busy:1, done:1, last:0, idx:0, data:0};
        vt[19] = '{start:0, rdy:1, valid:0, busy:0, done:0, last:0, idx:0, data:0};
        vt[20] = vt[19];
        base_data();
        set_bus();
        @(posedge clk); #1;
        for (int i = 0; i < 21; i++) begin
            io.start = vt[i].start;
            io.out_ready = vt[i].rdy;
            #1;
            chk($sformatf("t1_valid[%0d]", i), int'(io.out_valid), int'(vt[i].valid));
            chk($sformatf("t1_busy[%0d]", i),  int'(io.busy), int'(vt[i].busy));
            chk($sformatf("t1_done[%0d]", i),  int'(io.done), int'(vt[i].done));
            chk($sformatf("t1_last[%0d]", i),  int'(io.out_last), int'(vt[i].last));
            chk($sformatf("t1_err[%0d]", i),   int'(io.order_err), 0);
            if (vt[i].valid) begin
                chk($sformatf("t1_idx[%0d]", i),  int'(io.out_idx), vt[i].idx);
                chk($sformatf("t1_data[%0d]", i), int'(io.out_data), vt[i].data);
            end
            @(posedge clk); #1;
        end
        io.start = 1'b0;

        run_stream("t2_bp", 1, 1'b0);

        viol_data(); set_bus();
        run_stream("t3_viol", 0, 1'b0);
        base_data(); set_bus();
        run_stream("t3_clear", 0, 1'b0);

        run_stream("t4_snap", 0, 1'b1);
        set_bus();

        // Reset in the middle of a stream that has already flagged an order error.
        viol_data(); set_bus();
        io.out_ready = 1'b1;
        io.start = 1'b1;
        @(posedge clk); #1;
        io.start = 1'b0;
        cyc = 0;
        while (!(io.out_valid && io.out_idx == 9) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t5_at9",  int'(io.out_idx), 9);
        chk("t5_err1", int'(io.order_err), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("t5_valid", int'(io.out_valid), 0);
        chk("t5_busy",  int'(io.busy), 0);
        chk("t5_err0",  int'(io.order_err), 0);
        chk("t5_idx",   int'(io.out_idx), 0);
        base_data(); set_bus();
        run_stream("t5_restart", 0, 1'b0);

        // SETTLE=4: only the bus present in the 4th cycle after start is captured.
        io4.out_ready = 1'b1;
        io4.start = 1'b1;
        #1;
        chk("t6_busy0", int'(io4.busy), 0);
        @(posedge clk); #1;
        io4.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            io4.in_c = (c == 4) ? 48'd5 : '0;
            #1;
            chk($sformatf("t6_valid[%0d]", c), int'(io4.out_valid), 0);
            chk($sformatf("t6_busy[%0d]", c),  int'(io4.busy), 1);
            @(posedge clk); #1;
        end
        io4.in_c = '0;
        #1;
        chk("t6_first_valid", int'(io4.out_valid), 1);
        chk("t6_first_idx",   int'(io4.out_idx), 0);
        chk("t6_first_data",  int'(io4.out_data), 5);
        cyc = 0;
        while (!io4.done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t6_done", int'(io4.done), 1);
        chk("t6_cycles", cyc, NE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/merge_stream_out.md
Name: merge_stream_out

Overview:
- Reader side of the odd-even merge network (2n sorted elements of WIDTH bits).
- On a start pulse, waits a fixed settle time after the merger's input register loads, then snapshots the merged bus.
- Streams the 2n elements out one per transfer, lowest index first, over a valid/ready handshake.
- Checks non-decreasing order as it streams and flags any violation.

Parameters:
- WIDTH, 3, bits per element.
- n, 8, elements per input list; the merged bus holds 2n elements.
- SETTLE, 1, cycles from the accepted start to the snapshot; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse; accepted only in IDLE.
- in_c  input  2*n*WIDTH  merged bus; element k is in_c[(k+1)*WIDTH-1 : k*WIDTH].
- busy  output  1  high in every state except IDLE.
- out_data  output  WIDTH  current element.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_last  output  1  high with out_valid on element 2n-1.
- out_idx  output  $clog2(2n)  index of the current element.
- done  output  1  one-cycle pulse after the last transfer.
- order_err  output  1  sticky order-violation flag.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, counters and the snapshot register are 0. Reset applies on any clk edge with rst=1 and aborts a stream immediately.
- State IDLE: start=1 clears order_err and the settle counter, then moves to SETTLE. start is ignored in every other state.
- State SETTLE: the counter increments each cycle. When count reaches SETTLE-1:
  - capture in_c into the snapshot register;
  - set idx=0;
  - move to STREAM.
- State STREAM:
  - out_valid=1; out_data = snapshot element idx; out_idx=idx; out_last=(idx==2n-1).
  - A transfer happens when out_valid & out_ready.
  - Without a transfer, out_data, out_idx and out_last hold stable.
  - On a transfer with idx<2n-1: idx increments and the transferred element is stored as prev.
  - On a transfer with idx==2n-1: move to DONE.
- State DONE: done=1 for exactly one cycle, out_valid=0, then return to IDLE. A start in the DONE cycle is ignored.
- Latency: with out_ready held high, the first element is valid SETTLE+1 cycles after the start cycle. Elements then transfer one per cycle, so the full stream takes 2n cycles.
- Order check:
  - Applies on each transfer with idx>0, comparing unsigned out_data against prev.
  - out_data < prev sets order_err. Equal values are legal.
  - order_err stays set until the next accepted start or reset.
  - The stream continues after an error.
- in_c is not sampled after the snapshot, so the merger may be reloaded during STREAM.
- out_ready is don't-care outside STREAM.
- No combinational path from out_ready to out_valid or out_data.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, SETTLE, STREAM, DONE);
  - element-slice index helper;
  - index width constant $clog2(2n).
- One natural sub-module, stream_elem_mux: combinational 2n-to-1 WIDTH-bit selector over the snapshot register. The FSM, counters and order check stay in the top module.

Test Plan:
1. Basic stream: WIDTH=3, n=8, SETTLE=1; in_c elements 0,0,1,1,2,2,3,3,4,4,5,5,6,6,7,7; start pulse, out_ready=1.
   -> First out_valid 2 cycles after start; 16 consecutive transfers in that order; out_last only on idx 15; done pulses once; order_err=0.
2. Backpressure: same data; out_ready toggles 1,0,0,1 repeating.
   -> out_data and out_idx stable while not ready; no element skipped or duplicated; done after the 16th transfer.
3. Order violation: element 5=6, element 6=2, others non-decreasing.
   -> order_err rises on the transfer of idx 6 and stays 1 through done; the next start clears it.
4. Snapshot isolation: change in_c to all 7s one cycle after the snapshot.
   -> Streamed values equal the pre-change data.
5. Reset mid-operation: rst=1 at idx 9 for one cycle.
   -> Next cycle out_valid=0, busy=0, order_err=0, idx=0. A new start streams from idx 0.
6. Start filtering and settle: start asserted during STREAM and in the DONE cycle is ignored. SETTLE=4 run.
   -> Snapshot occurs 4 cycles after start; first valid on cycle 5.
